ct_ifu_spsram_arb: RTL

CT_IFU_SPSRAM_ARB -- requirements
Module: ct_ifu_spsram_arb

---
 rtl/ct_ifu_spsram_arb_pkg.sv | 13 +
 rtl/ct_ifu_spsram_inv_cnt.sv | 28 ++
 rtl/ct_ifu_spsram_arb.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ct_ifu_spsram_arb_pkg.sv
// Shared IFU SRAM-arbiter constants: array geometry, sweep end index and FSM encoding.
package ct_ifu_spsram_arb_pkg;

   localparam int ADDR_WIDTH = 10;
   localparam int DATA_WIDTH = 59;
   localparam int INV_LAST   = 1023;

   typedef enum logic {
      IDLE = 1'b0,
      INV  = 1'b1
   } inv_state_e;

endpackage

// File: rtl/ct_ifu_spsram_inv_cnt.sv
// Clear-sweep address counter: load clears to 0, inc steps by 1, is_last flags the final index.
// Single-cycle update, no backpressure; the owner decides when to step.
module ct_ifu_spsram_inv_cnt
   import ct_ifu_spsram_arb_pkg::*;
#(
   parameter int AW = ADDR_WIDTH
) (
   input  logic          forever_cpuclk,
   input  logic          cpurst_b,
   input  logic          load,
   input  logic          inc,
   output logic [AW-1:0] cnt,
   output logic          is_last
);

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= '0;
      end else if (inc) begin
         cnt <= cnt + AW'(1);
      end
   end

   assign is_last = (cnt == AW'(INV_LAST));

endmodule

// File: rtl/ct_ifu_spsram_arb.sv
// Single-port SRAM arbiter: clear sweep > write > read, combinational grants, read data one cycle later.
// Ungranted requests are not queued; requesters hold until granted.
module ct_ifu_spsram_arb #(
   parameter int ADDR_WIDTH = ct_ifu_spsram_arb_pkg::ADDR_WIDTH,
   parameter int DATA_WIDTH = ct_ifu_spsram_arb_pkg::DATA_WIDTH
) (
   input  logic                  forever_cpuclk,
   input  logic                  cpurst_b,
   input  logic                  inv_req,
   output logic                  inv_busy,
   output logic                  inv_done,
   input  logic                  wr_req,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [DATA_WIDTH-1:0] wr_mask,
   output logic                  wr_gnt,
   input  logic                  rd_req,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic                  rd_gnt,
   output logic                  rd_vld,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic [ADDR_WIDTH-1:0] sram_a,
   output logic                  sram_cen,
   output logic                  sram_gwen,
   output logic [DATA_WIDTH-1:0] sram_wen,
   output logic [DATA_WIDTH-1:0] sram_d,
   input  logic [DATA_WIDTH-1:0] sram_q
);

   import ct_ifu_spsram_arb_pkg::*;

   inv_state_e            state_q;
   inv_state_e            state_d;
   logic [ADDR_WIDTH-1:0] inv_cnt;
   logic                  cnt_load;
   logic                  cnt_inc;
   logic                  cnt_last;
   logic                  idle;

   ct_ifu_spsram_inv_cnt #(
      .AW (ADDR_WIDTH)
   ) u_inv_cnt (
      .forever_cpuclk (forever_cpuclk),
      .cpurst_b       (cpurst_b),
      .load           (cnt_load),
      .inc            (cnt_inc),
      .cnt            (inv_cnt),
      .is_last        (cnt_last)
   );

   // Reset lands in INV so every power-up starts with a full clear of the array.
   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         state_q <= INV;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_load = 1'b0;
      cnt_inc  = 1'b0;
      case (state_q)
         IDLE: begin
            if (inv_req) begin
               state_d  = INV;
               cnt_load = 1'b1;
            end
         end
         INV: begin
            cnt_inc = 1'b1;
            if (cnt_last) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = INV;
         end
      endcase
   end

   assign idle     = (state_q == IDLE);
   assign inv_busy = (state_q == INV);
   assign inv_done = inv_busy & cnt_last;

   assign wr_gnt = idle & ~inv_req & wr_req;
   assign rd_gnt = idle & ~inv_req & ~wr_req & rd_req;

   always_comb begin
      sram_a    = '0;
      sram_cen  = 1'b1;
      sram_gwen = 1'b1;
      sram_wen  = '1;
      sram_d    = '0;
      if (inv_busy) begin
         sram_a    = inv_cnt;
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = '0;
      end else if (wr_gnt) begin
         sram_a    = wr_addr;
         sram_cen  = 1'b0;
         sram_gwen = 1'b0;
         sram_wen  = ~wr_mask;
         sram_d    = wr_data;
      end else if (rd_gnt) begin
         sram_a    = rd_addr;
         sram_cen  = 1'b0;
      end
   end

   always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
      if (!cpurst_b) begin
         rd_vld <= 1'b0;
      end else begin
         rd_vld <= rd_gnt;
      end
   end

   assign rd_data = rd_vld ? sram_q : '0;

endmodule
